// File: rtl/cam_config_sequencer.sv
// Camera register-configuration sequencer.
// Walks a {reg,value} ROM and issues bus writes with retry on NACK.
module cam_config_sequencer #(
  parameter int          NUM_REGS       = 72,
  parameter logic [7:0]  SLAVE_ADDR     = 8'h42,
  parameter int          RESET_CYCLES   = 100000,
  parameter int          POWERUP_CYCLES = 100000,
  parameter int          DELAY_CYCLES   = 1000000,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        req_valid_o,
  output logic [23:0] req_data_o,
  input  logic        req_ready_i,
  input  logic        resp_done_i,
  input  logic        resp_nack_i,
  output logic        reset_cmos_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  error_index_o
);

  localparam logic [31:0] L_RST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] L_PWR  = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] L_DLY  = 32'(DELAY_CYCLES - 1);
  localparam logic [7:0]  L_NREG = 8'(NUM_REGS);
  localparam logic [7:0]  L_MAXR = 8'(MAX_RETRIES);

  localparam logic [15:0] L_END  = 16'hFFFF;
  localparam logic [15:0] L_WAIT = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESET,
    S_POWERUP,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  logic [31:0] r_timer;
  logic [7:0]  r_index;
  logic [7:0]  r_retries;
  logic        r_fetch_ph;
  logic [7:0]  r_rom_addr;
  logic        r_req_valid;
  logic [23:0] r_req_data;
  logic        r_cmos;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [7:0]  r_err_idx;

  logic        w_tmr_zero;
  logic [7:0]  w_idx_nxt;
  logic        w_last;

  assign w_tmr_zero = (r_timer == 32'd0);
  assign w_idx_nxt  = r_index + 8'd1;
  assign w_last     = (w_idx_nxt >= L_NREG);

  assign rom_addr_o    = r_rom_addr;
  assign req_valid_o   = r_req_valid;
  assign req_data_o    = r_req_data;
  assign reset_cmos_o  = r_cmos;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign error_o       = r_error;
  assign error_index_o = r_err_idx;

  // Sequencer FSM; every output is a register updated on the transition.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_index     <= '0;
      r_retries   <= '0;
      r_fetch_ph  <= 1'b0;
      r_rom_addr  <= '0;
      r_req_valid <= 1'b0;
      r_req_data  <= '0;
      r_cmos      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_idx   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            r_state    <= S_RESET;
            r_timer    <= L_RST;
            r_index    <= '0;
            r_retries  <= '0;
            r_rom_addr <= '0;
            r_cmos     <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_idx  <= '0;
          end
        end
        S_RESET: begin
          if (w_tmr_zero) begin
            r_state <= S_POWERUP;
            r_timer <= L_PWR;
            r_cmos  <= 1'b0;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_POWERUP: begin
          if (w_tmr_zero) begin
            r_state    <= S_FETCH;
            r_fetch_ph <= 1'b0;
            r_rom_addr <= r_index;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_FETCH: begin
          // First cycle presents the address, second consumes ROM data.
          if (!r_fetch_ph) begin
            r_fetch_ph <= 1'b1;
          end else begin
            r_fetch_ph <= 1'b0;
            r_retries  <= '0;
            if (rom_data_i == L_END) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (rom_data_i == L_WAIT) begin
              r_state <= S_DELAY;
              r_timer <= L_DLY;
            end else begin
              r_state     <= S_ISSUE;
              r_req_valid <= 1'b1;
              r_req_data  <= {SLAVE_ADDR, rom_data_i};
            end
          end
        end
        S_ISSUE: begin
          if (req_ready_i) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (resp_done_i) begin
            if (!resp_nack_i) begin
              r_index <= w_idx_nxt;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state    <= S_FETCH;
                r_fetch_ph <= 1'b0;
                r_rom_addr <= w_idx_nxt;
              end
            end else if (r_retries < L_MAXR) begin
              r_retries   <= r_retries + 8'd1;
              r_state     <= S_ISSUE;
              r_req_valid <= 1'b1;
            end else begin
              r_state   <= S_ERROR;
              r_error   <= 1'b1;
              r_busy    <= 1'b0;
              r_err_idx <= r_index;
            end
          end
        end
        S_DELAY: begin
          if (w_tmr_zero) begin
            r_index <= w_idx_nxt;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= S_FETCH;
              r_fetch_ph <= 1'b0;
              r_rom_addr <= w_idx_nxt;
            end
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Bench for cam_config_sequencer: directed ROM images,
// scoreboard of expected bus requests, scripted ACK/NACK responder.
module tb_cam_config_sequencer;

  localparam int NREG = 4;
  localparam int RSTC = 5;
  localparam int PWRC = 3;
  localparam int DLYC = 10;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [7:0]  rom_addr_o;
  logic [15:0] rom_data_i = 16'h0;
  logic        req_valid_o;
  logic [23:0] req_data_o;
  logic        req_ready_i;
  logic        resp_done_i = 1'b0;
  logic        resp_nack_i = 1'b0;
  logic        reset_cmos_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [7:0]  error_index_o;

  logic [15:0] rom [0:255];

  logic [23:0] exp_q [$];
  bit          nack_q [$];
  int          gap_log [$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          req_count = 0;
  int          rc_cnt = 0;
  int          idle_run = 0;
  int          resp_wait = 0;
  bit          pend_nack = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  cam_config_sequencer #(
    .NUM_REGS      (NREG),
    .SLAVE_ADDR    (8'h42),
    .RESET_CYCLES  (RSTC),
    .POWERUP_CYCLES(PWRC),
    .DELAY_CYCLES  (DLYC),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .req_valid_o  (req_valid_o),
    .req_data_o   (req_data_o),
    .req_ready_i  (req_ready_i),
    .resp_done_i  (resp_done_i),
    .resp_nack_i  (resp_nack_i),
    .reset_cmos_o (reset_cmos_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .error_index_o(error_index_o)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Monitor + responder: pops expected requests, answers 3 cycles later.
  always @(negedge clk) begin
    resp_done_i = 1'b0;
    resp_nack_i = 1'b0;
    if (reset_i) begin
      resp_wait = 0;
    end else begin
      if (reset_cmos_o) rc_cnt++;
      if (busy_o && !req_valid_o) idle_run++;
      if (resp_wait > 0) begin
        resp_wait--;
        if (resp_wait == 0) begin
          resp_done_i = 1'b1;
          resp_nack_i = pend_nack;
        end
      end
      if (req_valid_o && req_ready_i) begin
        req_count++;
        gap_log.push_back(idle_run);
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_req: got %0h required none", req_data_o);
        end else begin
          check("req_data", 64'(req_data_o), 64'(exp_q.pop_front()));
        end
        pend_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        resp_wait = 3;
      end
      if (req_valid_o) idle_run = 0;
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    nack_q.delete();
    gap_log.delete();
    req_count = 0;
    rc_cnt = 0;
    idle_run = 0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    req_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    clear_sb();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (done_o || error_o) hit = 1'b1;
    end
    if (!hit) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s_timeout: got no done/error required done/error", nm);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push4(input logic [15:0] a, b, c, d);
    exp_q.push_back({8'h42, a});
    exp_q.push_back({8'h42, b});
    exp_q.push_back({8'h42, c});
    exp_q.push_back({8'h42, d});
  endtask

  initial begin
    bit seen;
    int base;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    reset_i = 1'b1;
    start_i = 1'b0;
    req_ready_i = 1'b1;
    #1;
    check("reset_outs",
          64'({rom_addr_o, req_valid_o, req_data_o, reset_cmos_o,
               busy_o, done_o, error_o, error_index_o}), 64'h0);

    // Plain four-entry run, every write acknowledged.
    rom[0] = 16'h1111; rom[1] = 16'h2222;
    rom[2] = 16'h3333; rom[3] = 16'h4444; rom[4] = 16'h5555;
    do_reset();
    repeat (5) @(negedge clk);
    check("idle_no_req", 64'(req_count), 64'd0);
    push4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    pulse_start();
    wait_end("s1");
    check("s1_cmos_cycles", 64'(rc_cnt), 64'(RSTC));
    check("s1_req_count", 64'(req_count), 64'd4);
    check("s1_done", 64'({done_o, error_o, busy_o}), 64'b100);
    check("s1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Delay entry at index 2.
    rom[0] = 16'hA101; rom[1] = 16'hB202;
    rom[2] = 16'hFFF0; rom[3] = 16'hC303;
    do_reset();
    exp_q.push_back({8'h42, 16'hA101});
    exp_q.push_back({8'h42, 16'hB202});
    exp_q.push_back({8'h42, 16'hC303});
    pulse_start();
    wait_end("s2");
    check("s2_req_count", 64'(req_count), 64'd3);
    check("s2_done", 64'({done_o, error_o}), 64'b10);
    check("s2_gap", 64'((gap_log.size() == 3) ? gap_log[2] : -1),
          64'(3 + 2 + DLYC + 2));

    // End marker at index 1.
    rom[0] = 16'hD001; rom[1] = 16'hFFFF;
    rom[2] = 16'hD003; rom[3] = 16'hD004;
    do_reset();
    exp_q.push_back({8'h42, 16'hD001});
    pulse_start();
    wait_end("s3");
    check("s3_req_count", 64'(req_count), 64'd1);
    check("s3_done", 64'({done_o, error_o}), 64'b10);

    // Entry 2 NACKed beyond the retry budget, then restart.
    rom[0] = 16'h0101; rom[1] = 16'h0202;
    rom[2] = 16'h0303; rom[3] = 16'h0404;
    do_reset();
    exp_q.push_back({8'h42, 16'h0101});
    exp_q.push_back({8'h42, 16'h0202});
    for (int i = 0; i < 3; i++) exp_q.push_back({8'h42, 16'h0303});
    nack_q.push_back(1'b0);
    nack_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) nack_q.push_back(1'b1);
    pulse_start();
    wait_end("s4");
    check("s4_req_count", 64'(req_count), 64'd5);
    check("s4_error", 64'({done_o, error_o, busy_o}), 64'b010);
    check("s4_err_idx", 64'(error_index_o), 64'd2);
    clear_sb();
    push4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    pulse_start();
    #1;
    check("s4_restart_clr", 64'({error_o, reset_cmos_o, busy_o}), 64'b011);
    wait_end("s4r");
    check("s4r_cmos_cycles", 64'(rc_cnt), 64'(RSTC));
    check("s4r_req_count", 64'(req_count), 64'd4);
    check("s4r_done", 64'({done_o, error_o}), 64'b10);

    // Entry 1 NACKed once, then acknowledged.
    do_reset();
    exp_q.push_back({8'h42, 16'h0101});
    exp_q.push_back({8'h42, 16'h0202});
    exp_q.push_back({8'h42, 16'h0202});
    exp_q.push_back({8'h42, 16'h0303});
    exp_q.push_back({8'h42, 16'h0404});
    nack_q.push_back(1'b0);
    nack_q.push_back(1'b1);
    pulse_start();
    wait_end("s5");
    check("s5_req_count", 64'(req_count), 64'd5);
    check("s5_done", 64'({done_o, error_o}), 64'b10);

    // Back-pressure in ISSUE, then reset while waiting for the response.
    rom[0] = 16'h7E57;
    do_reset();
    req_ready_i = 1'b0;
    exp_q.push_back({8'h42, 16'h7E57});
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (req_valid_o) seen = 1'b1;
    end
    check("s6_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      check("s6_stall_hold", 64'({req_valid_o, req_data_o}),
            64'({1'b1, 8'h42, 16'h7E57}));
    end
    @(posedge clk);
    #1 req_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s6_in_wait", 64'({req_valid_o, busy_o}), 64'b01);
    reset_i = 1'b1;
    #1;
    check("s6_async_reset",
          64'({rom_addr_o, req_valid_o, req_data_o, reset_cmos_o,
               busy_o, done_o, error_o, error_index_o}), 64'h0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    check("s6_sb_empty", 64'(exp_q.size()), 64'd0);
    base = req_count;
    repeat (20) @(negedge clk);
    check("s6_no_req_after", 64'(req_count - base), 64'd0);
    check("s6_idle", 64'({busy_o, reset_cmos_o}), 64'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cam_config_sequencer.md
CAM_CONFIG_SEQUENCER -- requirements
Module: cam_config_sequencer

Interface
REQ-001 Parameters: NUM_REGS, default 72, number of ROM entries (1..255).
REQ-002 Parameters: SLAVE_ADDR, default 8'h42, 8-bit write address of the camera.
REQ-003 Parameters: RESET_CYCLES, default 100000, clk_i cycles reset_cmos_o held asserted.
REQ-004 Parameters: POWERUP_CYCLES, default 100000, clk_i cycles waited after reset release.
REQ-005 Parameters: DELAY_CYCLES, default 1000000, wait length for a delay entry.
REQ-006 Parameters: MAX_RETRIES, default 3, re-sends allowed per entry after NACK.
REQ-007 Ports: clk_i in 1, single clock; reset_i in 1, asynchronous active-high reset.
REQ-008 Ports: start_i in 1, begin/restart sequence (level-sampled in IDLE, DONE, ERROR).
REQ-009 Ports: rom_addr_o out 8, ROM index; rom_data_i in 16, {reg_addr, value}, valid one cycle after rom_addr_o changes.
REQ-010 Ports: req_valid_o out 1, req_data_o out 24 {SLAVE_ADDR, reg_addr, value}, req_ready_i in 1.
REQ-011 Ports: resp_done_i in 1, one-cycle transaction-complete pulse; resp_nack_i in 1, qualifies resp_done_i.
REQ-012 Ports: reset_cmos_o out 1 (active-high camera reset), busy_o out 1, done_o out 1, error_o out 1, error_index_o out 8.

Function
REQ-013 States: IDLE, RESET, POWERUP, FETCH, ISSUE, WAIT, DELAY, DONE, ERROR.
REQ-014 IDLE: start_i=1 -> RESET, timer loaded RESET_CYCLES-1, index cleared to 0.
REQ-015 RESET: reset_cmos_o=1; timer 0 -> POWERUP, timer loaded POWERUP_CYCLES-1; reset_cmos_o=0 in all other states.
REQ-016 POWERUP: timer 0 -> FETCH.
REQ-017 FETCH: rom_addr_o=index; next cycle latch rom_data_i, retry count cleared, then branch (FETCH lasts exactly 2 cycles).
REQ-018 Entry 16'hFFFF: end marker -> DONE immediately regardless of index.
REQ-019 Entry 16'hFFF0: delay -> DELAY, timer loaded DELAY_CYCLES-1; timer 0 -> index+1, FETCH; no bus request issued.
REQ-020 Any other entry -> ISSUE.
REQ-021 ISSUE: req_valid_o=1 with req_data_o stable; transfer when req_valid_o and req_ready_i both 1 in the same cycle -> WAIT; req_valid_o deasserts the cycle after transfer.
REQ-022 WAIT: resp_done_i=1 and resp_nack_i=0 -> index+1; index==NUM_REGS -> DONE, else FETCH.
REQ-023 WAIT: resp_done_i=1 and resp_nack_i=1 -> retries<MAX_RETRIES: retries+1, ISSUE (same entry); else ERROR, error_index_o=index.
REQ-024 resp_done_i outside WAIT is ignored.
REQ-025 DONE: done_o=1 held; ERROR: error_o=1 held, error_index_o held.
REQ-026 start_i=1 in DONE or ERROR -> clears done_o/error_o, -> RESET (full re-run); start_i ignored in all other states.
REQ-027 busy_o=1 in every state except IDLE, DONE, ERROR.
REQ-028 Timers are free of wrap: load value N-1, count down, exit when 0 (N cycles exactly); parameter value 0 is illegal.
REQ-029 Index width 8 bits; never exceeds NUM_REGS.

Reset
REQ-030 reset_i=1 at any time, including mid-transaction: state IDLE, timer 0, index 0, retries 0, rom_addr_o 0, req_valid_o 0, req_data_o 0, reset_cmos_o 0, busy_o 0, done_o 0, error_o 0, error_index_o 0, within the same cycle (asynchronous).
REQ-031 After reset release no bus request is issued until start_i is seen.

Verification
REQ-032 NUM_REGS=4, RESET_CYCLES=5, POWERUP_CYCLES=3, all ACK, req_ready_i=1 -> reset_cmos_o high exactly 5 cycles, 4 requests in ROM order with {8'h42, entry}, done_o=1 after 4th resp_done_i.
REQ-033 Entry 2 = 16'hFFF0, DELAY_CYCLES=10 -> 10-cycle gap with no req_valid_o, then entry 3 issued; only 3 requests total.
REQ-034 Entry 1 = 16'hFFFF with NUM_REGS=4 -> done_o after 1 request.
REQ-035 MAX_RETRIES=2, entry 2 NACKed 3 times -> 3 identical requests for entry 2, error_o=1, error_index_o=2; start_i pulse -> full re-run from reset pulse.
REQ-036 Entry 1 NACKed once then ACKed -> 2 requests for entry 1, sequence completes, error_o=0.
REQ-037 req_ready_i held 0 for 7 cycles in ISSUE -> req_valid_o and req_data_o stable throughout; reset_i asserted in WAIT -> all outputs zero immediately, IDLE.
